// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle mult/div sequencer with HI/LO registers.
// Latches the result at accept, releases it to HI/LO when the countdown ends.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        D_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   phi_q, phi_d;
  logic [31:0]   plo_q, plo_d;
  logic          pwe_q, pwe_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  md_op_e      op;
  logic        accept;
  logic        md_long;
  logic        dz;
  logic        ovf;
  logic [31:0] dvs_s;
  logic [31:0] dvs_u;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign op      = md_op_e'(md_op);
  assign busy    = (cnt_q != '0);
  assign accept  = start & ~busy;
  assign md_long = (op == OP_MULT) | (op == OP_MULTU) |
                   (op == OP_DIV)  | (op == OP_DIVU);
  assign stall   = D_md_use & (busy | (start & md_long));

  // Arithmetic datapath; divisors forced to 1 where the result is unused
  // or where signed overflow must yield dividend / remainder 0.
  always_comb begin
    dz     = (rt_data == 32'd0);
    ovf    = (rs_data == 32'h8000_0000) & (rt_data == 32'hFFFF_FFFF);
    dvs_s  = (dz | ovf) ? 32'd1 : rt_data;
    dvs_u  = dz ? 32'd1 : rt_data;
    prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u = {32'd0, rs_data} * {32'd0, rt_data};
    sq     = $signed(rs_data) / $signed(dvs_s);
    sr     = $signed(rs_data) % $signed(dvs_s);
    uq     = rs_data / dvs_u;
    ur     = rs_data % dvs_u;
  end

  // Next state: countdown/completion, then accept of a new op.
  always_comb begin
    cnt_d = cnt_q;
    phi_d = phi_q;
    plo_d = plo_q;
    pwe_d = pwe_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && pwe_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (accept) begin
      case (op)
        OP_MULT: begin
          {phi_d, plo_d} = prod_s;
          pwe_d = 1'b1;
          cnt_d = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {phi_d, plo_d} = prod_u;
          pwe_d = 1'b1;
          cnt_d = CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          phi_d = sr;
          plo_d = sq;
          pwe_d = ~dz;
          cnt_d = CW'(DIV_CYCLES);
        end
        OP_DIVU: begin
          phi_d = ur;
          plo_d = uq;
          pwe_d = ~dz;
          cnt_d = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = rs_data;
        OP_MTLO: lo_d = rs_data;
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      pwe_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwe_q <= pwe_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: table vectors, corner sequences and a random run
// against an arithmetic reference model of md_unit_ctrl.
module tb_md_unit_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        D_md_use;
  logic        busy, stall;
  logic [31:0] hi, lo;
  logic        busy1, stall1;
  logic [31:0] hi1, lo1;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .D_md_use(D_md_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  md_unit_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(DC)) dut1 (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .D_md_use(D_md_use),
    .busy(busy1), .stall(stall1), .hi(hi1), .lo(lo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; md_op = 3'd0; rs_data = '0; rt_data = '0;
    D_md_use = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the op semantics.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwe;
  int          m_rem;

  task automatic model_step(input logic rst, input logic st,
                            input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint sp, sa, sb, q, r;
    longint unsigned up, ua, ub;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pwe) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (st) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'd0, a}; ub = {32'd0, b};
      case (op)
        3'd1: begin
          sp = sa * sb;
          m_phi = sp[63:32]; m_plo = sp[31:0]; m_pwe = 1; m_rem = MC;
        end
        3'd2: begin
          up = ua * ub;
          m_phi = up[63:32]; m_plo = up[31:0]; m_pwe = 1; m_rem = MC;
        end
        3'd3: begin
          m_rem = DC; m_pwe = (b != 0);
          if (b != 0) begin
            q = sa / sb; r = sa % sb;
            m_plo = q[31:0]; m_phi = r[31:0];
          end
        end
        3'd4: begin
          m_rem = DC; m_pwe = (b != 0);
          if (b != 0) begin
            m_plo = 32'(ua / ub); m_phi = 32'(ua % ub);
          end
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  vec_t tbl[12];

  int n;
  logic        r_rst, r_st, r_dmu, e_stall;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3]  = '{3'd5, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFD, 0};
    tbl[4]  = '{3'd6, 32'h1234, 32'd0, 32'h1234, 32'h1234, 0};
    tbl[5]  = '{3'd4, 32'd7, 32'd0, 32'h1234, 32'h1234, DC};
    tbl[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC};
    tbl[7]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, DC};
    tbl[8]  = '{3'd0, 32'd5, 32'd5, 32'h1, 32'h7FFFFFFC, 0};
    tbl[9]  = '{3'd7, 32'd5, 32'd5, 32'h1, 32'h7FFFFFFC, 0};
    tbl[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, MC};
    tbl[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, DC};

    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    foreach (tbl[i]) begin
      start = 1'b1; md_op = tbl[i].op;
      rs_data = tbl[i].rs; rt_data = tbl[i].rt;
      tick();
      idle_in();
      wait_idle(n);
      check($sformatf("tbl%0d_cycles", i), 32'(n), 32'(tbl[i].cyc));
      check($sformatf("tbl%0d_hi", i), hi, tbl[i].ehi);
      check($sformatf("tbl%0d_lo", i), lo, tbl[i].elo);
    end

    // Stall covers the accept cycle and every busy cycle.
    do_reset();
    D_md_use = 1'b1; start = 1'b1; md_op = 3'd1;
    rs_data = 32'd5; rt_data = 32'd7;
    #1;
    check("stall_accept", 32'(stall), 32'd1);
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int c = 0; c < MC; c++) begin
      #1;
      check($sformatf("stall_busy%0d", c), 32'(stall), 32'd1);
      check($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
      tick();
    end
    #1;
    check("stall_release", 32'(stall), 32'd0);
    check("busy_release", 32'(busy), 32'd0);
    check("mflo_product", lo, 32'd35);

    // mtlo while busy is ignored; mtlo while idle writes.
    do_reset();
    start = 1'b1; md_op = 3'd1; rs_data = 32'd3; rt_data = 32'd4;
    tick();
    md_op = 3'd6; rs_data = 32'hAAAA;
    tick();
    idle_in();
    check("mtlo_busy_lo", lo, 32'd0);
    wait_idle(n);
    check("mtlo_busy_cycles", 32'(n), 32'(MC - 1));
    check("mtlo_busy_result", lo, 32'd12);
    start = 1'b1; md_op = 3'd6; rs_data = 32'hAAAA;
    tick();
    idle_in();
    check("mtlo_idle_lo", lo, 32'hAAAA);
    check("mtlo_idle_busy", 32'(busy), 32'd0);

    // Reset in the third busy cycle of a div aborts it.
    do_reset();
    start = 1'b1; md_op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    tick();
    idle_in();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (DC + 2) tick();
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    // One-cycle multiply instance.
    do_reset();
    start = 1'b1; md_op = 3'd1;
    rs_data = 32'hFFFFFFFE; rt_data = 32'd3;
    tick();
    idle_in();
    check("m1_busy", 32'(busy1), 32'd1);
    check("m1_hi_early", hi1, 32'd0);
    tick();
    check("m1_done", 32'(busy1), 32'd0);
    check("m1_hi", hi1, 32'hFFFFFFFF);
    check("m1_lo", lo1, 32'hFFFFFFFA);

    // Random run against the reference model.
    do_reset();
    model_step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    for (int k = 0; k < 3000; k++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 1) == 1);
      r_op  = 3'($urandom_range(0, 7));
      r_dmu = ($urandom_range(0, 1) == 1);
      r_a   = pick();
      r_b   = pick();
      reset = r_rst; start = r_st; md_op = r_op;
      rs_data = r_a; rt_data = r_b; D_md_use = r_dmu;
      e_stall = r_dmu & ((m_rem > 0) |
                (r_st & (r_op >= 3'd1) & (r_op <= 3'd4)));
      #1;
      check("rnd_stall", 32'(stall), 32'(e_stall));
      tick();
      model_step(r_rst, r_st, r_op, r_a, r_b);
      check("rnd_busy", 32'(busy), 32'(m_rem > 0));
      check("rnd_hi", hi, m_hi);
      check("rnd_lo", lo, m_lo);
    end
    reset = 1'b0;
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with the HI/LO architectural registers for the 5-stage MIPS pipeline.
- Sits in the E stage beside the ALU and is driven by the E-stage decode.
- Runs mult/multu/div/divu for a fixed number of cycles and generates the stall request that freezes the D/E boundary while a HI/LO consumer waits.
- Also executes mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is an MD op; qualifies md_op.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- D_md_use  input  1  D-stage instruction is any MD op or mfhi/mflo.
- busy  output  1  a mult/div operation is in flight.
- stall  output  1  stall request to the hazard logic.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: busy=0, stall=0, hi=0, lo=0, countdown=0, pending result=0. A reset during an operation aborts it, leaves HI/LO at 0, and drops busy on the next edge.
- busy is a registered output: busy = (countdown != 0).
- Start acceptance: start=1 with busy=0 accepts the op at that edge. start=1 with busy=1 is ignored entirely, and HI/LO are untouched. Upstream stall logic guarantees this case does not happen; it is still defined.
- mult: signed 64-bit product of rs_data*rt_data. multu: the same, unsigned. The result is latched into pending {hi,lo} at the accept edge and countdown loads MULT_CYCLES.
- div: signed; pending lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. divu: unsigned. countdown loads DIV_CYCLES.
- Divide by zero: countdown still loads DIV_CYCLES and busy asserts as usual. HI/LO retain their old values on completion (a pending-write-enable bit is cleared).
- Signed div overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- Countdown: each edge with countdown>0 decrements it. The edge where it goes 1->0 writes the pending values to hi/lo, and busy falls in that same cycle. busy is therefore high for exactly N cycles after the accept edge, and the new HI/LO is visible in the first cycle busy is 0.
- mthi/mtlo: accepted only when busy=0. They write rs_data to hi or lo at the accept edge, visible the next cycle. They never set busy.
- md_op 0 or 7 with start=1: no-op.
- stall is combinational: stall = D_md_use & (busy | (start & md_op in {1..4})). This covers the cycle in which a mult/div sits in E but has not yet raised busy.
- A D-stage consumer is released in the first cycle busy=0. Its mfhi/mflo reads the updated hi/lo with no further bypass.
- hi/lo change only at accept edges (mthi/mtlo), at completion edges, and at reset.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE, rt=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=0 with hi=lo=0x1234 beforehand -> busy 10 cycles; hi and lo stay 0x1234.
- mult accepted with D_md_use=1 in the same cycle -> stall=1 in the start cycle and during all 5 busy cycles; stall=0 in the first cycle busy=0, and mflo then sees the product.
- start=1 with mtlo rs=0xAAAA while busy=1 -> lo is unaffected by mtlo. After completion lo holds the mult result. A later mtlo with busy=0 -> lo=0xAAAA on the next cycle, and busy stays 0.
- Reset asserted on cycle 3 of a div -> busy=0, hi=lo=0 the next cycle; no completion write occurs afterward.
- Override MULT_CYCLES=1 -> busy high for one cycle and the result is visible in the following cycle.
